// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch front end: FSM states and the
// {pc, instruction} entry held in the prefetch FIFO.
package fetch_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned PC_W       = 32;
   localparam int unsigned INSTR_W    = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DISCARD
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Ring buffer of fetched {pc, instruction} entries; clear beats push and pop.
// Head reads as zero while empty.
module prefetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  fetch_entry_t     wr_data,
   input  logic             pop,
   input  logic             clear,
   output fetch_entry_t     rd_data,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction fetch with one outstanding memory request, a prefetch
// FIFO toward decode and branch redirect. Define FETCH_PERF_EN for perf counters.
module fetch_prefetch_buffer
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     DEPTH    = 4
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_valid,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               flush,
   input  logic [PC_W-1:0]    flush_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instruction,
   output logic [PC_W-1:0]    out_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_flushed
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   fetch_state_t     state;
   fetch_state_t     state_nxt;
   logic [PC_W-1:0]  fetch_pc;
   logic             issue;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   count_after;
   fetch_entry_t     head;
   fetch_entry_t     wr_entry;

   assign pop         = out_valid && out_ready && !flush;
   assign count_after = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);

   // Issue/accept decisions; a slot is reserved at issue so a push never overflows
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      push      = 1'b0;
      unique case (state)
         IDLE: begin
            if (!flush && (count < CNT_W'(DEPTH))) begin
               issue     = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (flush) begin
               state_nxt = imem_valid ? IDLE : DISCARD;
            end else if (imem_valid) begin
               push = 1'b1;
               if (count_after < (CNT_W+1)'(DEPTH)) issue = 1'b1;
               else                                  state_nxt = IDLE;
            end
         end
         DISCARD: begin
            if (imem_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
      end else begin
         state <= state_nxt;
         if (flush)      fetch_pc <= flush_pc & ~PC_W'(WORD_BYTES - 1);
         else if (issue) fetch_pc <= fetch_pc + PC_W'(WORD_BYTES);
      end
   end

   assign imem_req  = issue && !reset;
   assign imem_addr = fetch_pc;

   // In WAIT without flush, fetch_pc has already advanced one word past the request
   assign wr_entry = '{pc: fetch_pc - PC_W'(WORD_BYTES), instr: imem_data};

   prefetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wr_data (wr_entry),
      .pop     (pop),
      .clear   (flush),
      .rd_data (head),
      .count   (count)
   );

   assign out_valid       = (count != '0);
   assign out_instruction = head.instr;
   assign out_pc          = head.pc;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         if (push)  perf_fetched <= perf_fetched + 32'd1;
         if (flush) perf_flushed <= perf_flushed + 32'd1;
      end
   end
`endif

endmodule
